// File: rtl/multichannel_relay_module.sv
// Multichannel overcurrent relay: per-channel IDMT timing with dropout,
// latched trips and a shared pick-up, curve and time-multiplier setting.
module multichannel_relay_module #(
    parameter int CHANNELS        = 3,
    parameter int WIDTH           = 16,
    parameter int ACC_WIDTH       = 40,
    parameter int DROPOUT_SAMPLES = 4
) (
    input  logic                      clk_800hz,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] I_rms,
    input  logic [WIDTH-1:0]          I_p,
    input  logic [1:0]                curve_sel,
    input  logic [WIDTH-1:0]          tms,
    input  logic                      trip_clear,
    output logic [CHANNELS-1:0]       trip_phase,
    output logic                      trip_signal,
    output logic [CHANNELS-1:0]       pickup
);

    typedef enum logic [1:0] {IDLE, TIMING, DROPOUT, TRIPPED} state_e;

    // Sum width holds acc + largest increment without overflow
    localparam int SW = ((ACC_WIDTH > 2*WIDTH) ? ACC_WIDTH : 2*WIDTH) + 1;
    localparam int CW = $clog2(DROPOUT_SAMPLES + 1);
    localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

    logic [SW-1:0]       thr;
    logic [CHANNELS-1:0] trip_d;
    logic [CHANNELS-1:0] pick_d;

    always_comb begin
        thr = (curve_sel == 2'b00) ? SW'(tms) : (SW'(tms) << 8);
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [WIDTH-1:0]     cur;
        logic [WIDTH-1:0]     excess;
        logic                 oc;
        logic [2*WIDTH-1:0]   sq;
        logic [SW-1:0]        inc;
        logic [SW-1:0]        sum;
        logic [ACC_WIDTH-1:0] acc_upd;
        logic                 hit;
        state_e               st_q, st_d;
        logic [ACC_WIDTH-1:0] acc_q, acc_d;
        logic [CW-1:0]        cnt_q, cnt_d;
        logic                 oc_q, oc_d;

        assign cur    = I_rms[ch*WIDTH +: WIDTH];
        assign oc     = cur > I_p;
        assign excess = cur - I_p;
        assign sq     = {{WIDTH{1'b0}}, excess} * {{WIDTH{1'b0}}, excess};

        always_comb begin
            inc = SW'(1);
            unique case (curve_sel)
                2'b00:   inc = SW'(1);
                2'b01:   inc = SW'(excess);
                2'b10:   inc = SW'(sq >> 8);
                default: inc = SW'(1);
            endcase
            sum     = SW'(acc_q) + inc;
            acc_upd = (sum > ACC_MAX) ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
            hit     = (curve_sel == 2'b11) || (SW'(acc_upd) >= thr);
        end

        always_comb begin
            st_d  = st_q;
            acc_d = acc_q;
            cnt_d = cnt_q;
            oc_d  = sample_valid ? oc : oc_q;
            unique case (st_q)
                IDLE: begin
                    if (sample_valid && oc) begin
                        acc_d = acc_upd;
                        st_d  = hit ? TRIPPED : TIMING;
                    end
                end
                TIMING: begin
                    if (sample_valid && oc) begin
                        acc_d = acc_upd;
                        if (hit) st_d = TRIPPED;
                    end else if (sample_valid) begin
                        if (DROPOUT_SAMPLES <= 1) begin
                            st_d  = IDLE;
                            acc_d = '0;
                            cnt_d = '0;
                        end else begin
                            st_d  = DROPOUT;
                            cnt_d = CW'(1);
                        end
                    end
                end
                DROPOUT: begin
                    if (sample_valid && oc) begin
                        acc_d = acc_upd;
                        st_d  = hit ? TRIPPED : TIMING;
                    end else if (sample_valid) begin
                        if (int'(cnt_q) + 1 >= DROPOUT_SAMPLES) begin
                            st_d  = IDLE;
                            acc_d = '0;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                TRIPPED: begin
                    // A coincident sample decides; otherwise the last one does
                    if (trip_clear && !oc_d) begin
                        st_d  = IDLE;
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end
            endcase
        end

        always_ff @(posedge clk_800hz) begin
            if (reset) begin
                st_q  <= IDLE;
                acc_q <= '0;
                cnt_q <= '0;
                oc_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                oc_q  <= oc_d;
            end
        end

        assign trip_d[ch] = (st_d == TRIPPED);
        assign pick_d[ch] = (st_d == TIMING);
    end

    always_ff @(posedge clk_800hz) begin
        if (reset) begin
            trip_phase  <= '0;
            trip_signal <= 1'b0;
            pickup      <= '0;
        end else begin
            trip_phase  <= trip_d;
            trip_signal <= |trip_d;
            pickup      <= pick_d;
        end
    end

endmodule

// File: tb/tb_multichannel_relay_module.sv
// Directed bench for multichannel_relay_module: expected outputs are
// queued with each stimulus step and compared one clock later.
module tb_multichannel_relay_module;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [47:0] I_rms = '0;
    logic [15:0] I_p = 16'd1500;
    logic [1:0]  curve_sel = 2'b00;
    logic [15:0] tms = 16'd8;
    logic        trip_clear = 1'b0;
    logic [2:0]  trip_phase;
    logic        trip_signal;
    logic [2:0]  pickup;

    typedef struct packed {
        logic [2:0] tp;
        logic       ts;
        logic [2:0] pk;
    } exp_t;

    exp_t q[$];
    int   pass_n = 0;
    int   fail_n = 0;
    int   total_n = 0;

    multichannel_relay_module dut (
        .clk_800hz   (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .I_rms       (I_rms),
        .I_p         (I_p),
        .curve_sel   (curve_sel),
        .tms         (tms),
        .trip_clear  (trip_clear),
        .trip_phase  (trip_phase),
        .trip_signal (trip_signal),
        .pickup      (pickup)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic clr,
                        input logic [2:0] tp, input logic [2:0] pk, input string tag);
        exp_t e;
        sample_valid = v;
        I_rms        = {c, b, a};
        trip_clear   = clr;
        q.push_back('{tp: tp, ts: |tp, pk: pk});
        @(posedge clk);
        #1;
        e = q.pop_front();
        total_n++;
        assert ({trip_phase, trip_signal, pickup} === {e.tp, e.ts, e.pk}) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: got tp=%b ts=%b pk=%b, expected tp=%b ts=%b pk=%b",
                   tag, trip_phase, trip_signal, pickup, e.tp, e.ts, e.pk);
        end
        sample_valid = 1'b0;
        trip_clear   = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step(1'b1, 16'd2828, 16'd2828, 16'd2828, 1'b1, 3'b000, 3'b000, tag);
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("reset_state");

        // Normal load, inverse curve
        curve_sel = 2'b01;
        tms       = 16'd10;
        for (int i = 0; i < 64; i++)
            step(1'b1, 16'd1414, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b000, "normal_load");

        // Definite time on channel 1, then clear with and without oc
        do_reset("rst_dt");
        curve_sel = 2'b00;
        tms       = 16'd8;
        for (int i = 1; i <= 7; i++)
            step(1'b1, 16'd1414, 16'd2828, 16'd1414, 1'b0, 3'b000, 3'b010, "dt_timing");
        step(1'b1, 16'd1414, 16'd2828, 16'd1414, 1'b0, 3'b010, 3'b000, "dt_trip8");
        step(1'b1, 16'd1414, 16'd2828, 16'd1414, 1'b1, 3'b010, 3'b000, "clear_while_oc");
        step(1'b0, 16'd1414, 16'd1000, 16'd1414, 1'b1, 3'b010, 3'b000, "clear_reg_oc");
        step(1'b1, 16'd1414, 16'd1000, 16'd1414, 1'b0, 3'b010, 3'b000, "tripped_holds");
        step(1'b0, 16'd1414, 16'd1000, 16'd1414, 1'b1, 3'b000, 3'b000, "clear_released");

        // Inverse curve: ch0 and ch2 timing together
        do_reset("rst_inv");
        curve_sel = 2'b01;
        tms       = 16'd10;
        step(1'b1, 16'd2828, 16'd1414, 16'd1600, 1'b0, 3'b000, 3'b101, "inv_s1");
        step(1'b1, 16'd2828, 16'd1414, 16'd1600, 1'b0, 3'b001, 3'b100, "inv_ch0_trip");
        for (int i = 3; i <= 25; i++)
            step(1'b1, 16'd2828, 16'd1414, 16'd1600, 1'b0, 3'b001, 3'b100, "inv_ch2_timing");
        step(1'b1, 16'd2828, 16'd1414, 16'd1600, 1'b0, 3'b101, 3'b000, "inv_ch2_trip26");

        // Dropout with recovery; idle cycles must not advance the counter
        do_reset("rst_drop_a");
        curve_sel = 2'b00;
        tms       = 16'd8;
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b001, "drop_a_oc");
        for (int i = 0; i < 2; i++)
            step(1'b1, 16'd1000, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b000, "drop_a_low");
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'd1000, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b000, "drop_a_hold");
        step(1'b1, 16'd1000, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b000, "drop_a_low3");
        for (int i = 0; i < 2; i++)
            step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b001, "drop_a_resume");
        step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b001, 3'b000, "drop_a_trip");

        // Dropout to IDLE: a full fresh threshold is required
        do_reset("rst_drop_b");
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b001, "drop_b_oc");
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'd1000, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b000, "drop_b_low");
        for (int i = 0; i < 7; i++)
            step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b001, "drop_b_fresh");
        step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b001, 3'b000, "drop_b_trip");

        // Instantaneous boundary and coincident clear
        do_reset("rst_inst");
        curve_sel = 2'b11;
        tms       = 16'd100;
        step(1'b1, 16'd1500, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b000, "inst_equal");
        step(1'b1, 16'd1501, 16'd1414, 16'd1414, 1'b0, 3'b001, 3'b000, "inst_trip");
        step(1'b1, 16'd1501, 16'd1414, 16'd1414, 1'b1, 3'b001, 3'b000, "clr_coinc_oc");
        step(1'b1, 16'd1000, 16'd1414, 16'd1414, 1'b1, 3'b000, 3'b000, "clr_coinc_low");
        step(1'b1, 16'd1414, 16'd1414, 16'd1501, 1'b0, 3'b100, 3'b000, "inst_ch2");

        // tms=0 trips on first oc sample
        do_reset("rst_tms0");
        curve_sel = 2'b01;
        tms       = 16'd0;
        step(1'b1, 16'd1501, 16'd1414, 16'd1414, 1'b0, 3'b001, 3'b000, "tms0_trip");

        // Very inverse: excess 64 -> increment 16, threshold 256
        do_reset("rst_vinv");
        curve_sel = 2'b10;
        tms       = 16'd1;
        for (int i = 1; i <= 15; i++)
            step(1'b1, 16'd1564, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b001, "vinv_timing");
        step(1'b1, 16'd1564, 16'd1414, 16'd1414, 1'b0, 3'b001, 3'b000, "vinv_trip16");

        // Reset mid-timing discards accumulated time
        do_reset("rst_mid_a");
        curve_sel = 2'b00;
        tms       = 16'd8;
        for (int i = 0; i < 5; i++)
            step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b001, "mid_pre");
        do_reset("mid_reset");
        for (int i = 0; i < 7; i++)
            step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b000, 3'b001, "mid_post");
        step(1'b1, 16'd2828, 16'd1414, 16'd1414, 1'b0, 3'b001, 3'b000, "mid_trip");

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
